// File: rtl/gray_to_rgb_pipe.sv
// Pipelined grayscale-to-RGB converter: two elastic register stages with
// frame-start-latched display mode and threshold.
module gray_to_rgb_pipe #(
    parameter int                IN_W  = 8,
    parameter int                OUT_W = 4,
    parameter int                ROUND = 1,
    parameter logic [OUT_W-1:0]  HL_R  = 4'hF,
    parameter logic [OUT_W-1:0]  HL_G  = 4'h0,
    parameter logic [OUT_W-1:0]  HL_B  = 4'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_gray,
    input  logic             in_sof,
    input  logic             in_eol,
    input  logic [1:0]       cfg_mode,
    input  logic [IN_W-1:0]  cfg_thresh,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_r,
    output logic [OUT_W-1:0] out_g,
    output logic [OUT_W-1:0] out_b,
    output logic             out_sof,
    output logic             out_eol,
    output logic [1:0]       active_mode
);

    typedef enum logic [1:0] {
        MODE_GRAY   = 2'd0,
        MODE_INVERT = 2'd1,
        MODE_THRESH = 2'd2,
        MODE_BINARY = 2'd3
    } mode_t;

    localparam int              S    = IN_W - OUT_W;
    localparam logic [IN_W:0]   HALF = (IN_W+1)'(2 ** (S - 1));
    localparam logic [IN_W:0]   VMAX = (IN_W+1)'(2 ** OUT_W - 1);

    mode_t             mode_sh;
    logic [IN_W-1:0]   thr_sh;

    logic              s1_valid;
    logic [OUT_W-1:0]  s1_v;
    logic              s1_hit;
    mode_t             s1_mode;
    logic              s1_sof;
    logic              s1_eol;

    logic              accept;
    logic              s2_load;
    mode_t             eff_mode;
    logic [IN_W-1:0]   eff_thr;
    logic [IN_W-1:0]   g;
    logic [IN_W:0]     rnd_sum;
    logic [IN_W:0]     rnd_shr;
    logic [OUT_W-1:0]  v_rnd;
    logic [OUT_W-1:0]  v_trunc;
    logic [OUT_W-1:0]  v_new;
    logic              hit_new;
    logic [OUT_W-1:0]  nxt_r;
    logic [OUT_W-1:0]  nxt_g;
    logic [OUT_W-1:0]  nxt_b;

    assign s2_load     = !out_valid || out_ready;
    assign in_ready    = !s1_valid || s2_load;
    assign accept      = in_valid && in_ready;
    assign active_mode = mode_sh;

    // A sof beat is processed with the config it carries, not the stale shadow.
    always_comb begin
        eff_mode = in_sof ? mode_t'(cfg_mode) : mode_sh;
        eff_thr  = in_sof ? cfg_thresh : thr_sh;
        g        = (eff_mode == MODE_INVERT) ? ~in_gray : in_gray;
        rnd_sum  = {1'b0, g} + HALF;
        rnd_shr  = rnd_sum >> S;
        v_rnd    = (rnd_shr > VMAX) ? '1 : rnd_shr[OUT_W-1:0];
        v_trunc  = OUT_W'(g >> S);
        v_new    = (ROUND != 0) ? v_rnd : v_trunc;
        hit_new  = (in_gray >= eff_thr);
    end

    always_comb begin
        nxt_r = s1_v;
        nxt_g = s1_v;
        nxt_b = s1_v;
        case (s1_mode)
            MODE_THRESH: begin
                if (s1_hit) begin
                    nxt_r = HL_R;
                    nxt_g = HL_G;
                    nxt_b = HL_B;
                end
            end
            MODE_BINARY: begin
                nxt_r = s1_hit ? '1 : '0;
                nxt_g = s1_hit ? '1 : '0;
                nxt_b = s1_hit ? '1 : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_sh <= MODE_GRAY;
            thr_sh  <= '1;
        end else if (accept && in_sof) begin
            mode_sh <= mode_t'(cfg_mode);
            thr_sh  <= cfg_thresh;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_v     <= '0;
            s1_hit   <= 1'b0;
            s1_mode  <= MODE_GRAY;
            s1_sof   <= 1'b0;
            s1_eol   <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_v    <= v_new;
                s1_hit  <= hit_new;
                s1_mode <= eff_mode;
                s1_sof  <= in_sof;
                s1_eol  <= in_eol;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_r     <= '0;
            out_g     <= '0;
            out_b     <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_r   <= nxt_r;
                out_g   <= nxt_g;
                out_b   <= nxt_b;
                out_sof <= s1_sof;
                out_eol <= s1_eol;
            end
        end
    end

endmodule

// File: tb/tb_gray_to_rgb_pipe.sv
// Scoreboard bench for gray_to_rgb_pipe with default parameters
// (IN_W=8, OUT_W=4, ROUND=1, highlight F/0/0).
module tb_gray_to_rgb_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_gray = '0;
    logic        in_sof = 1'b0;
    logic        in_eol = 1'b0;
    logic [1:0]  cfg_mode = '0;
    logic [7:0]  cfg_thresh = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_r;
    logic [3:0]  out_g;
    logic [3:0]  out_b;
    logic        out_sof;
    logic        out_eol;
    logic [1:0]  active_mode;

    gray_to_rgb_pipe #(.IN_W(8), .OUT_W(4), .ROUND(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_gray(in_gray),
        .in_sof(in_sof), .in_eol(in_eol),
        .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .out_sof(out_sof), .out_eol(out_eol),
        .active_mode(active_mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] rgb;
        logic        sof;
        logic        eol;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   bp_random = 1'b0;
    logic or_fixed = 1'b1;
    logic [1:0] m_mode = 2'd0;
    logic [7:0] m_thr = 8'hFF;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        out_ready = bp_random ? 1'($urandom_range(0, 1)) : or_fixed;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Independent reference: integer rounding (g+8)/16 with saturation.
    function automatic logic [11:0] model(input logic [7:0] gv, input logic [1:0] m,
                                          input logic [7:0] thr);
        int gg;
        int v;
        logic [3:0] v4;
        logic hit;
        gg  = (m == 2'd1) ? (255 - int'(gv)) : int'(gv);
        v   = (gg + 8) / 16;
        if (v > 15) v = 15;
        v4  = 4'(v);
        hit = (gv >= thr);
        case (m)
            2'd2:    model = hit ? 12'hF00 : {v4, v4, v4};
            2'd3:    model = hit ? 12'hFFF : 12'h000;
            default: model = {v4, v4, v4};
        endcase
    endfunction

    // Monitor: pops the scoreboard on every output transfer, checks stall stability.
    logic        stall_prev = 1'b0;
    logic [13:0] held = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_hold", 32'({out_r, out_g, out_b, out_sof, out_eol}), 32'(held));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h expected no beat", {out_r, out_g, out_b});
                end else begin
                    e = sb.pop_front();
                    chk("rgb", 32'({out_r, out_g, out_b}), 32'(e.rgb));
                    chk("sideband", 32'({out_sof, out_eol}), 32'({e.sof, e.eol}));
                    if (e.lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
                end
            end
            stall_prev = out_valid && !out_ready;
            held = {out_r, out_g, out_b, out_sof, out_eol};
        end
    end

    task automatic send(input logic [7:0] gv, input logic sof, input logic eol,
                        input logic [1:0] m, input logic [7:0] thr,
                        input logic [11:0] exp_rgb, input bit lat);
        int n;
        exp_t e;
        n = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_gray = gv; in_sof = sof; in_eol = eol;
        cfg_mode = m; cfg_thresh = thr;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stayed 0, expected 1");
                break;
            end
        end
        e.rgb = exp_rgb; e.sof = sof; e.eol = eol; e.cyc = cyc; e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] gv;
        logic [1:0] rm;
        logic [7:0] rt;
        logic       sof;

        // Reset
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_rgb", 32'({out_r, out_g, out_b}), 32'd0);
        chk("rst_sideband", 32'({out_sof, out_eol}), 32'd0);
        chk("rst_active_mode", 32'(active_mode), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_active_mode", 32'(active_mode), 32'd0);

        // GRAY stream, back to back, non-sof cfg set to junk that must be ignored
        send(8'h00, 1'b1, 1'b0, 2'd0, 8'hFF, 12'h000, 1'b1);
        send(8'h07, 1'b0, 1'b0, 2'd3, 8'h00, 12'h000, 1'b1);
        send(8'h08, 1'b0, 1'b0, 2'd3, 8'h00, 12'h111, 1'b1);
        send(8'h7F, 1'b0, 1'b0, 2'd3, 8'h00, 12'h888, 1'b1);
        send(8'hF8, 1'b0, 1'b0, 2'd3, 8'h00, 12'hFFF, 1'b1);
        send(8'hFF, 1'b0, 1'b1, 2'd3, 8'h00, 12'hFFF, 1'b1);
        idle(3);
        chk("gray_active_mode", 32'(active_mode), 32'd0);

        // THRESH latched on sof; mode 3 / thr 0 afterwards must be ignored
        send(8'h00, 1'b1, 1'b0, 2'd2, 8'h80, 12'h000, 1'b0);
        send(8'h7F, 1'b0, 1'b0, 2'd3, 8'h00, 12'h888, 1'b0);
        send(8'h80, 1'b0, 1'b0, 2'd3, 8'h00, 12'hF00, 1'b0);
        send(8'hFF, 1'b0, 1'b1, 2'd3, 8'h00, 12'hF00, 1'b0);
        idle(2);
        chk("thresh_active_mode", 32'(active_mode), 32'd2);

        // INVERT
        send(8'h10, 1'b1, 1'b0, 2'd1, 8'h00, 12'hFFF, 1'b0);
        send(8'hF0, 1'b0, 1'b0, 2'd0, 8'hFF, 12'h111, 1'b0);
        send(8'h00, 1'b0, 1'b1, 2'd0, 8'hFF, 12'hFFF, 1'b0);
        idle(2);
        chk("invert_active_mode", 32'(active_mode), 32'd1);

        // BINARY, boundary at thr
        send(8'h10, 1'b1, 1'b0, 2'd3, 8'h10, 12'hFFF, 1'b0);
        send(8'h0F, 1'b0, 1'b0, 2'd0, 8'hFF, 12'h000, 1'b0);
        send(8'h80, 1'b0, 1'b1, 2'd0, 8'hFF, 12'hFFF, 1'b0);
        idle(2);
        chk("binary_active_mode", 32'(active_mode), 32'd3);
        drain();

        // Random backpressure, random gaps, new frame every 100 beats
        bp_random = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            gv  = 8'($urandom_range(0, 255));
            rm  = 2'($urandom_range(0, 3));
            rt  = 8'($urandom_range(0, 255));
            sof = (i % 100 == 0);
            if (sof) begin
                m_mode = rm;
                m_thr  = rt;
            end
            send(gv, sof, (i % 100 == 99), rm, rt, model(gv, m_mode, m_thr), 1'b0);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(1);
        bp_random = 1'b0;
        or_fixed  = 1'b1;
        drain();

        // Fill both stages under backpressure, then reset mid-stream
        or_fixed = 1'b0;
        repeat (2) @(negedge clk);
        send(8'h40, 1'b1, 1'b0, 2'd2, 8'h80, 12'h444, 1'b0);
        send(8'h90, 1'b0, 1'b0, 2'd2, 8'h80, 12'hF00, 1'b0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_active_mode", 32'(active_mode), 32'd0);
        or_fixed = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_active_mode", 32'(active_mode), 32'd0);

        // Stream resumes cleanly with default GRAY shadow
        send(8'h7F, 1'b0, 1'b1, 2'd3, 8'h00, 12'h888, 1'b1);
        idle(1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
